rotate_seq_ctrl: RTL and testbench
==================================

# rotate_seq_ctrl

Sequencer that owns one left-rotate register and turns it into a request/response rotate engine. It accepts a data word plus rotate amount over a valid/ready handshake, loads the register, pulses its shift enable for exactly the requested number of cycles, then presents the rotated word over a second valid/ready handshake. It sits between a producer that issues rotate jobs and a consumer that collects results, and processes one job at a time.

## Interface
- `DW`, 4, data width (≥2)
- `AW`, $clog2(DW), rotate-amount width; amounts 0..DW-1
- `clk`  in  1  clock, rising edge
- `sync_rst`  in  1  reset, synchronous and active-high
- `in_valid`  in  1  job offered
- `in_ready`  out  1  controller can accept a job
- `in_data`  in  DW  word to rotate
- `in_amt`  in  AW  number of left-rotate steps
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer takes result
- `out_data`  out  DW  rotated word
- `busy`  out  1  job in progress (state ≠ IDLE)

## Operation
- FSM states: IDLE, ROT, DONE.
- IDLE: `in_ready`=1. On an edge with `in_valid & in_ready`: register loads `in_data`, `cnt`<=`in_amt`; next state ROT if `in_amt`≠0, else DONE.
- ROT: register `en`=1, `load`=0; each edge rotates once (`q`<={q[DW-2:0],q[DW-1]}) and decrements `cnt`; on the edge where `cnt`==1, next state DONE.
- DONE: `out_valid`=1, `out_data`=`q`, `en`=0 (register holds). On an edge with `out_ready`: next state IDLE.
- `in_ready`=0 in ROT and DONE; `in_valid` there is ignored, with no queuing.
- `out_data` equals `q` in all states; it is only meaningful while `out_valid`=1.
- `load` and `en` are never asserted in the same cycle.
- Reset (any state, any cycle): state IDLE, `cnt`=0, register cleared to 0. This aborts an in-flight job; no result is produced.
- Reset values: `in_ready`=0 while `sync_rst`=1 (gated), 1 in the first cycle after reset; `out_valid`=0; `out_data`=0; `busy`=0.

## Timing
- Job accepted at edge k: `q`=`in_data` after edge k.
- `out_valid` rises after edge k+`in_amt`. For amount 0, that is immediately after edge k.
- Result handshake at edge m: `out_valid` falls and `in_ready` rises after edge m. There is no same-cycle bypass, so the next job can be accepted at edge m+1 at the earliest.
- Minimum job period: `in_amt`+2 cycles.
- With `out_ready` low, DONE persists indefinitely and `out_data` stays stable.
- Simultaneous `out_ready` and `in_valid` in DONE: only the result handshake occurs, because `in_ready`=0.

## Structure
- Shared package `rotate_pkg`:
  - state enum `rot_state_t` {IDLE, ROT, DONE}
  - width helper for `AW`
- Sub-module: the existing `left_rotate_reg`, instantiated once.
  - Ports `clk`, `sync_rst`, `load`, `en`, `data`, `q`.
  - `data`=`in_data`. Its `load` has priority over `en`.
- Controller RTL holds only the FSM, `cnt`, and the handshake logic.

## Test plan
- Reset: hold `sync_rst` 2 cycles → `out_valid`=0, `out_data`=0, `busy`=0; `in_ready`=1 in the first cycle after release.
- Zero amount: `in_data`=4'b1011, `in_amt`=0, `out_ready`=1 → `out_valid` high the cycle after acceptance, `out_data`=4'b1011; `in_ready` back high one cycle later.
- Single and max rotate:
  - 4'b1001, amt 1 → 4'b0011 after 1 cycle.
  - 4'b0001, amt 3 → 4'b1000 after 3 cycles, with intermediate `q` values 0010 and 0100.
- Backpressure and ignored input: 4'b0110, amt 2, `out_ready` low 5 cycles, `in_valid` held high with 4'b1111 → `out_data`=4'b1001 stable and `in_ready`=0 throughout; result taken when `out_ready` rises; then 4'b1111 is accepted as a new job.
- Reset mid-job: 4'b0101, amt 3, `sync_rst` pulsed after the first rotate → no `out_valid`, `q`=0, IDLE; a following job 4'b1100, amt 1 → 4'b1001.
- Back-to-back: 20 random jobs with random `out_ready` gaps → each result equals the reference rotate, in order, with the period equal to `in_amt`+2 when `out_ready`=1.

Source files
------------

// File: rtl/rotate_pkg.sv
// Shared types and width helpers for the rotate sequencer and its datapath.
package rotate_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } rot_state_t;

    // Rotate-amount width; a 1-bit field is the floor so tiny words still get a port.
    function automatic int amt_width(input int dw);
        return (dw < 2) ? 1 : $clog2(dw);
    endfunction

endpackage

// File: rtl/rotate_seq_ctrl_if.sv
// Job/result handshake bundle between a producer/consumer (master) and the rotate engine (slave).
interface rotate_seq_ctrl_if #(
    parameter int DW = 4,
    parameter int AW = rotate_pkg::amt_width(DW)
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [AW-1:0] in_amt;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;

    modport master (
        output in_valid, in_data, in_amt, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_amt, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/left_rotate_reg.sv
// Loadable left-rotate register; load wins over enable, synchronous active-high clear.
module left_rotate_reg #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic          load,
    input  logic          en,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] q
);
    logic [DW-1:0] q_d;
    logic [DW-1:0] q_q;

    // Next-value selection: load, rotate one step, or hold.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = data;
        end else if (en) begin
            q_d = {q_q[DW-2:0], q_q[DW-1]};
        end else begin
            q_d = q_q;
        end
    end

    // Register state with synchronous clear.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/rotate_seq_ctrl.sv
// Rotate job sequencer: accepts a word and amount, steps the rotate register, returns the result.
module rotate_seq_ctrl
    import rotate_pkg::*;
#(
    parameter int DW = 4,
    parameter int AW = amt_width(DW)
) (
    input  logic                clk,
    input  logic                sync_rst,
    rotate_seq_ctrl_if.slave    bus
);
    rot_state_t    state_d;
    rot_state_t    state_q;
    logic [AW-1:0] cnt_d;
    logic [AW-1:0] cnt_q;
    logic          load_s;
    logic          en_s;
    logic          in_ready_s;
    logic [DW-1:0] q_s;

    // Gated by reset so no job is taken on the clearing edge.
    assign in_ready_s = (state_q == IDLE) && !sync_rst;

    // Next-state, step counter and register control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_s  = 1'b0;
        en_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_s) begin
                    load_s  = 1'b1;
                    cnt_d   = bus.in_amt;
                    state_d = (bus.in_amt != AW'(0)) ? ROT : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            ROT: begin
                en_s  = 1'b1;
                cnt_d = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = ROT;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Controller state; reset aborts any in-flight job.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    left_rotate_reg #(.DW(DW)) u_rot (
        .clk      (clk),
        .sync_rst (sync_rst),
        .load     (load_s),
        .en       (en_s),
        .data     (bus.in_data),
        .q        (q_s)
    );

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = q_s;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Randomised and directed bench for rotate_seq_ctrl against an arithmetic rotate model.
module tb_rotate_seq_ctrl;
    localparam int DW = 4;
    localparam int AW = 2;

    logic clk;
    logic sync_rst;
    int   n_cmp;
    int   n_err;
    int   cyc;
    int   exp_q[$];
    int   prev_t;
    int   prev_a;
    int   prev_stall;
    bit   have_prev;

    rotate_seq_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    rotate_seq_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Left rotate expressed as modular multiply plus the wrapped-out high bits.
    function automatic int ref_rot(input int x, input int a);
        return ((x * (1 << a)) % (1 << DW)) + (x >> (DW - a));
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full job: accept, follow the rotate trace, stall the consumer, take the result.
    task automatic do_job(input int d, input int a, input int stall, input bit hold_junk);
        int w;
        int got;
        int t_acc;
        w = 0;
        while (!bus.in_ready && w < 10) begin
            tick();
            w++;
        end
        check_val("accept_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_data   = DW'(d);
        bus.in_amt    = AW'(a);
        bus.out_ready = (stall == 0);
        tick();
        t_acc = cyc;
        if (hold_junk) bus.in_data = 4'hF;
        else           bus.in_valid = 1'b0;
        if (have_prev && prev_stall == 0)
            check_val("period", 32'(t_acc - prev_t), 32'(prev_a + 2));
        have_prev  = 1'b1;
        prev_t     = t_acc;
        prev_a     = a;
        prev_stall = stall;
        exp_q.push_back(ref_rot(d, a));
        for (int s = 0; s <= a; s++) begin
            if (s > 0) tick();
            check_val("trace_q", 32'(bus.out_data), 32'(ref_rot(d, s)));
            check_val("out_valid_step", 32'(bus.out_valid), 32'(s == a));
            check_val("in_ready_busy", 32'(bus.in_ready), 32'd0);
            check_val("busy", 32'(bus.busy), 32'd1);
        end
        for (int st = 0; st < stall; st++) begin
            tick();
            check_val("stall_valid", 32'(bus.out_valid), 32'd1);
            check_val("stall_data", 32'(bus.out_data), 32'(ref_rot(d, a)));
            check_val("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        got = int'(bus.out_data);
        tick();
        check_val("result", 32'(got), 32'(exp_q.pop_front()));
        check_val("post_valid", 32'(bus.out_valid), 32'd0);
        check_val("post_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("post_busy", 32'(bus.busy), 32'd0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        have_prev = 1'b0;
        sync_rst      = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.out_ready = 1'b0;

        tick();
        tick();
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_out_data", 32'(bus.out_data), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_in_ready_gated", 32'(bus.in_ready), 32'd0);
        sync_rst = 1'b0;
        #1;
        check_val("rel_in_ready", 32'(bus.in_ready), 32'd1);

        do_job(4'b1011, 0, 0, 1'b0);
        do_job(4'b1001, 1, 0, 1'b0);
        do_job(4'b0001, 3, 0, 1'b0);
        do_job(4'b0110, 2, 5, 1'b1);
        do_job(4'b1111, 1, 0, 1'b0);

        bus.in_valid = 1'b1;
        bus.in_data  = 4'b0101;
        bus.in_amt   = 2'd3;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check_val("mid_first_rot", 32'(bus.out_data), 32'(4'b1010));
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        #1;
        check_val("mid_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("mid_q", 32'(bus.out_data), 32'd0);
        check_val("mid_busy", 32'(bus.busy), 32'd0);
        check_val("mid_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("mid_no_result", 32'(bus.out_valid), 32'd0);
        end
        have_prev = 1'b0;
        do_job(4'b1100, 1, 0, 1'b0);

        have_prev = 1'b0;
        for (int j = 0; j < 20; j++) begin
            int st;
            st = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            do_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), st, 1'b0);
        end
        check_val("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
